usb1bd_reg_arb: RTL

Two-master arbiter for the USB1 device register bus. It shares the single register port of the USB device register block between master 0 (CPU-side bridge) and master 1 (hardware endpoint sequencer). It serialises their accesses with round-robin or fixed priority. Each access runs as one framed cs/ack transaction, and a timeout guards against a missing ack. The arbiter sits between the bus bridges and the register block, in the same `mclk` domain.

---
 rtl/usb1bd_reg_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/usb1bd_reg_arb.sv
// Two-master arbiter for the USB1 device register port: one framed cs/ack
// access at a time, round-robin or fixed priority, with an ack timeout.
module usb1bd_reg_arb #(
   parameter int unsigned TO_CYCLES = 15,
   parameter bit          FIXED_PRI = 1'b0
) (
   input  logic        mclk,
   input  logic        reset_n,
   input  logic        m0_cs,
   input  logic        m0_wr,
   input  logic [3:0]  m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_be,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic        m1_cs,
   input  logic        m1_wr,
   input  logic [3:0]  m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_be,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic        reg_cs,
   output logic        reg_wr,
   output logic [3:0]  reg_addr,
   output logic [31:0] reg_wdata,
   output logic [3:0]  reg_be,
   input  logic [31:0] reg_rdata,
   input  logic        reg_ack,
   output logic        arb_busy,
   output logic        arb_gnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

   state_t     state_q;
   logic [7:0] cnt_q;
   logic       last_gnt_q;
   logic       win_d;

   // On a tie, round-robin favours whoever was not served by the last acked access.
   always_comb begin
      win_d = 1'b0;
      if (m0_cs && m1_cs) begin
         win_d = FIXED_PRI ? 1'b0 : ~last_gnt_q;
      end else if (m1_cs) begin
         win_d = 1'b1;
      end
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_gnt_q <= 1'b1;
         reg_cs     <= 1'b0;
         reg_wr     <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         reg_be     <= '0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m1_err     <= 1'b0;
         arb_busy   <= 1'b0;
         arb_gnt    <= 1'b0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         m0_err <= 1'b0;
         m1_err <= 1'b0;
         case (state_q)
            IDLE: begin
               if (m0_cs || m1_cs) begin
                  arb_gnt   <= win_d;
                  reg_cs    <= 1'b1;
                  reg_wr    <= win_d ? m1_wr    : m0_wr;
                  reg_addr  <= win_d ? m1_addr  : m0_addr;
                  reg_wdata <= win_d ? m1_wdata : m0_wdata;
                  reg_be    <= win_d ? m1_be    : m0_be;
                  cnt_q     <= '0;
                  arb_busy  <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               // Ack is checked first so it beats a timeout landing in the same cycle.
               if (reg_ack) begin
                  reg_cs     <= 1'b0;
                  last_gnt_q <= arb_gnt;
                  state_q    <= DONE;
                  if (arb_gnt) begin
                     m1_ack <= 1'b1;
                     if (!reg_wr) m1_rdata <= reg_rdata;
                  end else begin
                     m0_ack <= 1'b1;
                     if (!reg_wr) m0_rdata <= reg_rdata;
                  end
               end else if (cnt_q == TO_LAST) begin
                  reg_cs  <= 1'b0;
                  state_q <= DONE;
                  if (arb_gnt) begin
                     m1_ack   <= 1'b1;
                     m1_err   <= 1'b1;
                     m1_rdata <= '0;
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_err   <= 1'b1;
                     m0_rdata <= '0;
                  end
               end else if (cnt_q != 8'hFF) begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               arb_busy <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               reg_cs   <= 1'b0;
               arb_busy <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

endmodule
